// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU writeback path.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [0:0] {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/load_extender.sv
// Selects the addressed byte/half of a returned load word and sign- or zero-extends it.
module load_extender
    import cpu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        // Halfword loads are assumed aligned, so only addr_lo[1] picks the half.
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            FUNCT3_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LH:  result = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LBU: result = {24'h000000, byte_sel};
            FUNCT3_LHU: result = {16'h0000, half_sel};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write driver: retires ALU results directly and loads once memory data returns.
//
//   state        | meaning
//   WB_IDLE      | ready for a retiring instruction from execute
//   WB_WAIT_LOAD | load accepted, waiting for the memory data pulse
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_result,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_load_funct3,
    input  logic [1:0]        ex_load_addr_lo,
    input  logic              mem_read_data_valid,
    input  logic [XLEN-1:0]   mem_read_data,
    output logic              rf_write_enable,
    output logic [REG_AW-1:0] rf_write_addr,
    output logic [XLEN-1:0]   rf_write_data,
    output logic              retire,
    output logic              pending_valid,
    output logic [REG_AW-1:0] pending_rd,
    output logic              protocol_error
);

    wb_state_t         state;
    logic [REG_AW-1:0] cap_rd;
    logic [2:0]        cap_funct3;
    logic [1:0]        cap_addr_lo;
    logic [XLEN-1:0]   load_data;
    logic              accept;

    assign ex_ready      = (state == WB_IDLE);
    assign accept        = ex_valid & ex_ready;
    assign pending_valid = (state == WB_WAIT_LOAD);
    assign pending_rd    = pending_valid ? cap_rd : '0;

    load_extender u_load_extender (
        .word    (mem_read_data),
        .funct3  (cap_funct3),
        .addr_lo (cap_addr_lo),
        .result  (load_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= WB_IDLE;
            cap_rd          <= '0;
            cap_funct3      <= '0;
            cap_addr_lo     <= '0;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            retire          <= 1'b0;
            protocol_error  <= 1'b0;
        end else begin
            rf_write_enable <= 1'b0;
            retire          <= 1'b0;
            case (state)
                WB_IDLE: begin
                    // Data with no outstanding load is dropped but flagged until reset.
                    if (mem_read_data_valid) begin
                        protocol_error <= 1'b1;
                    end
                    if (accept) begin
                        if (ex_is_load) begin
                            cap_rd      <= ex_rd;
                            cap_funct3  <= ex_load_funct3;
                            cap_addr_lo <= ex_load_addr_lo;
                            state       <= WB_WAIT_LOAD;
                        end else begin
                            rf_write_enable <= (ex_rd != '0);
                            rf_write_addr   <= ex_rd;
                            rf_write_data   <= ex_result;
                            retire          <= 1'b1;
                        end
                    end
                end
                WB_WAIT_LOAD: begin
                    if (mem_read_data_valid) begin
                        rf_write_enable <= (cap_rd != '0);
                        rf_write_addr   <= cap_rd;
                        rf_write_data   <= load_data;
                        retire          <= 1'b1;
                        state           <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vector bench for writeback_unit: ALU and load retirement, hazards, error and reset.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_load_funct3;
    logic [1:0]  ex_load_addr_lo;
    logic        mem_read_data_valid;
    logic [31:0] mem_read_data;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        retire;
    logic        pending_valid;
    logic [4:0]  pending_rd;
    logic        protocol_error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_load;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] word;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    writeback_unit dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .ex_valid            (ex_valid),
        .ex_ready            (ex_ready),
        .ex_rd               (ex_rd),
        .ex_result           (ex_result),
        .ex_is_load          (ex_is_load),
        .ex_load_funct3      (ex_load_funct3),
        .ex_load_addr_lo     (ex_load_addr_lo),
        .mem_read_data_valid (mem_read_data_valid),
        .mem_read_data       (mem_read_data),
        .rf_write_enable     (rf_write_enable),
        .rf_write_addr       (rf_write_addr),
        .rf_write_data       (rf_write_data),
        .retire              (retire),
        .pending_valid       (pending_valid),
        .pending_rd          (pending_rd),
        .protocol_error      (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        ex_valid        = 1'b1;
        ex_is_load      = v.is_load;
        ex_rd           = v.rd;
        ex_result       = v.result;
        ex_load_funct3  = v.funct3;
        ex_load_addr_lo = v.addr_lo;
        chk($sformatf("v%0d_ready_before", idx), {31'd0, ex_ready}, 32'd1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        if (!v.is_load) begin
            chk($sformatf("v%0d_we", idx), {31'd0, rf_write_enable}, {31'd0, v.exp_we});
            chk($sformatf("v%0d_addr", idx), {27'd0, rf_write_addr}, {27'd0, v.rd});
            chk($sformatf("v%0d_data", idx), rf_write_data, v.exp_data);
            chk($sformatf("v%0d_retire", idx), {31'd0, retire}, 32'd1);
        end else begin
            chk($sformatf("v%0d_no_retire_on_accept", idx), {30'd0, retire, rf_write_enable}, 32'd0);
            chk($sformatf("v%0d_pending_valid", idx), {31'd0, pending_valid}, 32'd1);
            chk($sformatf("v%0d_pending_rd", idx), {27'd0, pending_rd}, {27'd0, v.rd});
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_ready_while_wait", idx), {31'd0, ex_ready}, 32'd0);
            mem_read_data_valid = 1'b1;
            mem_read_data       = v.word;
            #1;
            chk($sformatf("v%0d_ready_pulse_cycle", idx), {31'd0, ex_ready}, 32'd0);
            @(posedge clk);
            #1;
            mem_read_data_valid = 1'b0;
            mem_read_data       = 32'h0;
            chk($sformatf("v%0d_we", idx), {31'd0, rf_write_enable}, {31'd0, v.exp_we});
            chk($sformatf("v%0d_addr", idx), {27'd0, rf_write_addr}, {27'd0, v.rd});
            chk($sformatf("v%0d_data", idx), rf_write_data, v.exp_data);
            chk($sformatf("v%0d_retire", idx), {31'd0, retire}, 32'd1);
            chk($sformatf("v%0d_ready_after", idx), {31'd0, ex_ready}, 32'd1);
            chk($sformatf("v%0d_pending_clear", idx), {31'd0, pending_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_idle_quiet", idx), {30'd0, retire, rf_write_enable}, 32'd0);
        chk($sformatf("v%0d_data_hold", idx), rf_write_data, v.exp_data);
    endtask

    initial begin
        int retire_cnt;

        //            load  f3      alo    rd     result        word          we    data
        vecs[0]  = '{1'b0, 3'b000, 2'd0, 5'd5,  32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b000, 2'd0, 5'd0,  32'h00001234, 32'h0,        1'b0, 32'h00001234};
        vecs[2]  = '{1'b1, 3'b000, 2'd2, 5'd7,  32'h0,        32'h00800000, 1'b1, 32'hFFFFFF80};
        vecs[3]  = '{1'b1, 3'b100, 2'd2, 5'd8,  32'h0,        32'h00800000, 1'b1, 32'h00000080};
        vecs[4]  = '{1'b1, 3'b001, 2'd2, 5'd9,  32'h0,        32'h80010000, 1'b1, 32'hFFFF8001};
        vecs[5]  = '{1'b1, 3'b101, 2'd0, 5'd10, 32'h0,        32'h0000F00D, 1'b1, 32'h0000F00D};
        vecs[6]  = '{1'b1, 3'b010, 2'd0, 5'd11, 32'h0,        32'h12345678, 1'b1, 32'h12345678};
        vecs[7]  = '{1'b1, 3'b000, 2'd3, 5'd12, 32'h0,        32'h7F000000, 1'b1, 32'h0000007F};
        vecs[8]  = '{1'b1, 3'b001, 2'd3, 5'd13, 32'h0,        32'hFFFF0000, 1'b1, 32'hFFFFFFFF};
        vecs[9]  = '{1'b1, 3'b011, 2'd1, 5'd14, 32'h0,        32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        vecs[10] = '{1'b1, 3'b010, 2'd0, 5'd0,  32'h0,        32'h55AA55AA, 1'b0, 32'h55AA55AA};
        vecs[11] = '{1'b1, 3'b000, 2'd1, 5'd15, 32'h0,        32'h0000AB00, 1'b1, 32'hFFFFFFAB};

        reset_n             = 1'b0;
        ex_valid            = 1'b0;
        ex_rd               = '0;
        ex_result           = '0;
        ex_is_load          = 1'b0;
        ex_load_funct3      = '0;
        ex_load_addr_lo     = '0;
        mem_read_data_valid = 1'b0;
        mem_read_data       = '0;
        #1;
        chk("reset_outputs", {rf_write_enable, retire, pending_valid, protocol_error}, 4'b0000);
        chk("reset_addr_data", rf_write_data | {27'd0, rf_write_addr} | {27'd0, pending_rd}, 32'd0);
        chk("reset_ready", {31'd0, ex_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Back-to-back ALU retirements, one write per cycle.
        retire_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            ex_valid   = 1'b1;
            ex_is_load = 1'b0;
            ex_rd      = 5'(i);
            ex_result  = 32'h100 + 32'(i);
            @(posedge clk);
            #1;
            if (retire) retire_cnt++;
            chk($sformatf("b2b%0d_we", i), {31'd0, rf_write_enable}, 32'd1);
            chk($sformatf("b2b%0d_addr", i), {27'd0, rf_write_addr}, 32'(i));
            chk($sformatf("b2b%0d_data", i), rf_write_data, 32'h100 + 32'(i));
        end
        @(negedge clk);
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_retire_count", 32'(retire_cnt), 32'd4);
        chk("b2b_quiet_after", {30'd0, retire, rf_write_enable}, 32'd0);

        // Stray memory data while idle.
        @(negedge clk);
        mem_read_data_valid = 1'b1;
        mem_read_data       = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        mem_read_data_valid = 1'b0;
        chk("perr_set", {31'd0, protocol_error}, 32'd1);
        chk("perr_no_write", {30'd0, retire, rf_write_enable}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("perr_sticky", {31'd0, protocol_error}, 32'd1);

        // Reset in the middle of an outstanding load drops it.
        @(negedge clk);
        ex_valid        = 1'b1;
        ex_is_load      = 1'b1;
        ex_rd           = 5'd20;
        ex_load_funct3  = 3'b010;
        ex_load_addr_lo = 2'd0;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        chk("rst_mid_pending_before", {27'd0, pending_rd}, 32'd20);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_pending_valid", {31'd0, pending_valid}, 32'd0);
        chk("rst_mid_perr_cleared", {31'd0, protocol_error}, 32'd0);
        chk("rst_mid_ready", {31'd0, ex_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_release_quiet%0d", i),
                {29'd0, pending_valid, retire, rf_write_enable}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
